// File: rtl/bcd_to_b16.sv
// bcd_to_b16: sequential converter from five BCD digits to a 16-bit unsigned binary value
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request conversion, sampled only while idle
//   D5..D1   in   BCD digits, D5 = ten-thousands ... D1 = units
//   busy     out  high while digits are being accumulated
//   done     out  one-cycle pulse, result and flags valid from this cycle
//   result   out  converted value, saturates to 16'hFFFF on overflow
//   overflow out  value exceeded 65535
//   invalid  out  illegal digit seen (10..14, or blank after a real digit)
module bcd_to_b16 #(
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  D5,
   input  logic [3:0]  D4,
   input  logic [3:0]  D3,
   input  logic [3:0]  D2,
   input  logic [3:0]  D1,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        overflow,
   output logic        invalid
);
   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
   state_t      state_q, state_d;
   logic [19:0] dig_q, dig_d;
   logic [16:0] acc_q, acc_d;
   logic [2:0]  step_q, step_d;
   logic        lead_q, lead_d;
   logic        err_q, err_d;
   logic [15:0] res_q, res_d;
   logic        ovf_q, ovf_d;
   logic        inv_q, inv_d;
   logic [3:0]  cur;
   logic        skip;
   logic        legal;
   logic [16:0] mac;
   // digits are consumed from the top nibble; the register shifts left each step
   assign cur   = dig_q[19:16];
   assign skip  = lead_q && (cur == BLANK_CODE);
   assign legal = cur <= 4'd9;
   // acc*10 + digit as acc*8 + acc*2 + digit; 99999 fits in 17 bits so no wrap for legal input
   assign mac   = {acc_q[13:0], 3'b000} + {acc_q[15:0], 1'b0} + {13'd0, cur};
   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      acc_d   = acc_q;
      step_d  = step_q;
      lead_d  = lead_q;
      err_d   = err_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      inv_d   = inv_q;
      case (state_q)
         IDLE: if (start) begin
            dig_d   = {D5, D4, D3, D2, D1};
            acc_d   = '0;
            step_d  = '0;
            lead_d  = 1'b1;
            err_d   = 1'b0;
            state_d = CONVERT;
         end
         CONVERT: begin
            acc_d  = skip ? acc_q : mac;
            lead_d = lead_q & ~legal;
            err_d  = err_q | ~(skip | legal);
            dig_d  = {dig_q[15:0], 4'h0};
            step_d = step_q + 3'd1;
            if (step_q == 3'd4) begin
               state_d = DONE;
               inv_d   = err_d;
               ovf_d   = ~err_d & acc_d[16];
               res_d   = err_d ? 16'h0000 : (acc_d[16] ? 16'hFFFF : acc_d[15:0]);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dig_q   <= '0;
         acc_q   <= '0;
         step_q  <= '0;
         lead_q  <= 1'b0;
         err_q   <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         lead_q  <= lead_d;
         err_q   <= err_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         inv_q   <= inv_d;
      end
   end
   assign busy     = state_q == CONVERT;
   assign done     = state_q == DONE;
   assign result   = res_q;
   assign overflow = ovf_q;
   assign invalid  = inv_q;
endmodule

// File: tb/tb_bcd_to_b16.sv
// tb_bcd_to_b16: scoreboard-based self-checking bench for bcd_to_b16
module tb_bcd_to_b16;
   typedef struct {
      logic [15:0] r;
      logic        o;
      logic        i;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  D5 = 4'h0, D4 = 4'h0, D3 = 4'h0, D2 = 4'h0, D1 = 4'h0;
   logic        busy, done, overflow, invalid;
   logic [15:0] result;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   bcd_to_b16 dut (
      .clk(clk), .rst(rst), .start(start),
      .D5(D5), .D4(D4), .D3(D3), .D2(D2), .D1(D1),
      .busy(busy), .done(done), .result(result),
      .overflow(overflow), .invalid(invalid)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   // independent reference model of the digit accumulation rules
   function automatic exp_t model(input logic [19:0] dg);
      exp_t e;
      int   acc = 0;
      bit   lead = 1'b1;
      bit   err = 1'b0;
      for (int k = 4; k >= 0; k--) begin
         logic [3:0] d;
         d = dg[k*4 +: 4];
         if (d == 4'hF && lead) begin
         end else if (d <= 4'd9) begin
            acc = acc * 10 + int'(d);
            lead = 1'b0;
         end else err = 1'b1;
      end
      e.i = err;
      e.o = !err && acc > 65535;
      e.r = err ? 16'h0 : (acc > 65535 ? 16'hFFFF : acc[15:0]);
      return e;
   endfunction
   // scoreboard: every done pulse pops and compares one expected result
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: result=%h ovf=%b inv=%b with empty scoreboard", result, overflow, invalid);
         end else begin
            e = sb.pop_front();
            if ({result, overflow, invalid} !== {e.r, e.o, e.i}) begin
               errors++;
               $display("FAIL conversion: got result=%h ovf=%b inv=%b expected result=%h ovf=%b inv=%b",
                        result, overflow, invalid, e.r, e.o, e.i);
            end
         end
      end
   end
   task automatic push(input logic [15:0] r, input logic o, input logic i);
      exp_t e;
      e.r = r; e.o = o; e.i = i;
      sb.push_back(e);
   endtask
   // leaves the bench at the negedge right after the accepting edge
   task automatic start_conv(input logic [3:0] a, b, c, d, e);
      @(negedge clk);
      D5 = a; D4 = b; D3 = c; D2 = d; D1 = e;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      D5 = ~a; D4 = ~b; D3 = ~c; D2 = ~d; D1 = ~e;
   endtask
   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done not seen within 20 cycles");
      end
   endtask
   task automatic conv(input logic [3:0] a, b, c, d, e, input logic [15:0] r, input logic o, input logic i);
      push(r, o, i);
      start_conv(a, b, c, d, e);
      wait_done();
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid: got %b expected 0", invalid); end
   endtask
   task automatic test_basic();
      push(16'h3039, 1'b0, 1'b0);
      start_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: cycle %0d got busy=%b done=%b expected busy=1 done=0", k, busy, done);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b expected 0", done); end
   endtask
   task automatic test_boundary();
      conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 16'hFFFF, 1'b0, 1'b0);
      conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 16'hFFFF, 1'b1, 1'b0);
      conv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 16'hFFFF, 1'b1, 1'b0);
   endtask
   task automatic test_blanks();
      conv(4'hF, 4'hF, 4'd0, 4'd4, 4'd2, 16'd42, 1'b0, 1'b0);
      conv(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 16'd0, 1'b0, 1'b0);
      conv(4'hF, 4'd1, 4'hF, 4'd2, 4'd3, 16'd0, 1'b0, 1'b1);
      conv(4'd1, 4'd2, 4'hA, 4'd4, 4'd5, 16'd0, 1'b0, 1'b1);
   endtask
   task automatic test_continuous_start();
      int base;
      @(negedge clk);
      base = done_cnt;
      for (int k = 0; k < 20; k++) begin
         logic [19:0] dg;
         dg = 20'($urandom_range(0, 20'hFFFFF));
         {D5, D4, D3, D2, D1} = dg;
         start = 1'b1;
         if (k % 7 == 0) sb.push_back(model(dg));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (10) @(negedge clk);
      checks += 2;
      if (done_cnt - base !== 3) begin errors++; $display("FAIL continuous_count: got %0d conversions expected 3", done_cnt - base); end
      if (sb.size() !== 0) begin errors++; $display("FAIL continuous_pending: got %0d pending expected 0", sb.size()); end
   endtask
   task automatic test_reset_mid();
      int base;
      conv(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 16'd100, 1'b0, 1'b0);
      start_conv(4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
      repeat (3) @(negedge clk);
      base = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 2;
      if ({busy, done, overflow, invalid} !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_ctrl: got busy=%b done=%b ovf=%b inv=%b expected all 0", busy, done, overflow, invalid);
      end
      if (result !== 16'h0) begin errors++; $display("FAIL midreset_result: got %h expected 0000", result); end
      repeat (8) @(negedge clk);
      checks++;
      if (done_cnt !== base) begin errors++; $display("FAIL midreset_nodone: got %0d done pulses expected 0", done_cnt - base); end
      conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 16'd7, 1'b0, 1'b0);
   endtask
   task automatic test_back_to_back();
      conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h3039, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (result !== 16'h3039) begin errors++; $display("FAIL hold_result: got %h expected 3039", result); end
      end
      conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0);
   endtask
   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_blanks();
      test_continuous_start();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL final_pending: got %0d pending expected 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
